// File: rtl/fe_mulx.sv
// ----------------------------------------------------------------------------
// fe_mulx : iterative GF(2^255-19) multiplier, ref10 radix-2^25.5 signed limbs
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fe_mulx #(
  parameter int LATENCY = 30
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [319:0] op_a,
  input  logic [319:0] op_b,
  input  logic         valid,
  output logic [319:0] res,
  output logic         done
);

  localparam int CW = $clog2(LATENCY);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL   = 3'd1,
    S_CARRY = 3'd2,
    S_PAD   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                state, state_nx;
  logic                  start;
  logic [CW-1:0]         cnt;
  logic [319:0]          f, g;
  logic signed [63:0]    h    [10];
  logic signed [63:0]    h_nx [10];
  logic signed [63:0]    mac  [10];
  logic [3:0]            row, step, cl, cn;
  logic signed [31:0]    fj;
  logic signed [63:0]    ch, cc;

  // ref10 carry chain order
  function automatic logic [3:0] carry_limb(input logic [3:0] s);
    case (s)
      4'd0:    carry_limb = 4'd0;
      4'd1:    carry_limb = 4'd4;
      4'd2:    carry_limb = 4'd1;
      4'd3:    carry_limb = 4'd5;
      4'd4:    carry_limb = 4'd2;
      4'd5:    carry_limb = 4'd6;
      4'd6:    carry_limb = 4'd3;
      4'd7:    carry_limb = 4'd7;
      4'd8:    carry_limb = 4'd4;
      4'd9:    carry_limb = 4'd8;
      4'd10:   carry_limb = 4'd9;
      default: carry_limb = 4'd0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    case (state)
      S_IDLE, S_DONE: if (valid) begin
        start    = 1'b1;
        state_nx = S_MUL;
      end
      S_MUL:   if (cnt == CW'(9))         state_nx = S_CARRY;
      S_CARRY: if (cnt == CW'(21))        state_nx = S_PAD;
      S_PAD:   if (cnt == CW'(LATENCY-1)) state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign row  = (state == S_MUL) ? cnt[3:0] : 4'd0;
  assign step = 4'(cnt - CW'(10));
  assign fj   = f[{row, 5'd0} +: 32];

  // One MAC per accumulator: target t receives f_row * g_k with k = (t - row) mod 10
  for (genvar t = 0; t < 10; t++) begin : g_mac
    logic [3:0]         k;
    logic signed [31:0] gk;
    logic signed [63:0] prod, scaled;
    assign k      = (4'(t) >= row) ? 4'(t) - row : 4'(t) + 4'd10 - row;
    assign gk     = g[{k, 5'd0} +: 32];
    assign prod   = $signed({{32{fj[31]}}, fj}) * $signed({{32{gk[31]}}, gk});
    assign scaled = (k > 4'(t)) ? prod * 64'sd19 : prod;
    assign mac[t] = (row[0] & k[0]) ? scaled <<< 1 : scaled;
  end

  always_comb begin
    for (int i = 0; i < 10; i++) h_nx[i] = h[i];
    cl = carry_limb(step);
    cn = (cl == 4'd9) ? 4'd0 : cl + 4'd1;
    ch = h[cl];
    if (cl[0]) cc = (ch + 64'sd16777216) >>> 25;
    else       cc = (ch + 64'sd33554432) >>> 26;
    case (state)
      S_MUL: begin
        for (int i = 0; i < 10; i++) h_nx[i] = h[i] + mac[i];
      end
      S_CARRY: begin
        h_nx[cl] = cl[0] ? ch - (cc <<< 25) : ch - (cc <<< 26);
        // the top limb's carry wraps to limb 0 with weight 19 (2^255 = 19 mod p)
        h_nx[cn] = (cl == 4'd9) ? h[cn] + cc * 64'sd19 : h[cn] + cc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      f    <= '0;
      g    <= '0;
      res  <= '0;
      done <= 1'b0;
      for (int i = 0; i < 10; i++) h[i] <= '0;
    end else if (start) begin
      cnt  <= '0;
      f    <= op_a;
      g    <= op_b;
      done <= 1'b0;
      for (int i = 0; i < 10; i++) h[i] <= '0;
    end else begin
      if (state == S_MUL || state == S_CARRY || state == S_PAD) cnt <= cnt + CW'(1);
      if (state == S_MUL || state == S_CARRY) begin
        for (int i = 0; i < 10; i++) h[i] <= h_nx[i];
      end
      if (state == S_PAD && cnt == CW'(LATENCY-1)) begin
        for (int i = 0; i < 10; i++) res[32*i +: 32] <= h[i][31:0];
        done <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fe_mulx.sv
// ----------------------------------------------------------------------------
// tb_fe_mulx : randomized check of fe_mulx against a ref10 fe_mul model
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fe_mulx;

  logic         clk = 1'b0;
  logic         rst;
  logic [319:0] op_a, op_b;
  logic         valid;
  logic [319:0] res;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;

  fe_mulx #(.LATENCY(30)) dut (
    .clk   (clk),
    .rst   (rst),
    .op_a  (op_a),
    .op_b  (op_b),
    .valid (valid),
    .res   (res),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Straight transcription of ref10 fe_mul: full schoolbook sum, then the carry chain
  function automatic logic [319:0] fe_mul_ref(input logic [319:0] a, input logic [319:0] b);
    longint fa [10];
    longint gb [10];
    longint hh [10];
    int     order [12];
    longint p, c;
    int     li, w;
    logic [319:0] r;
    order = '{0, 4, 1, 5, 2, 6, 3, 7, 4, 8, 9, 0};
    for (int i = 0; i < 10; i++) begin
      fa[i] = longint'($signed(a[32*i +: 32]));
      gb[i] = longint'($signed(b[32*i +: 32]));
      hh[i] = 0;
    end
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 10; j++) begin
        p = fa[i] * gb[j];
        if ((i % 2 == 1) && (j % 2 == 1)) p = p * 2;
        if (i + j >= 10) hh[i + j - 10] += 19 * p;
        else             hh[i + j]      += p;
      end
    end
    for (int s = 0; s < 12; s++) begin
      li = order[s];
      w  = (li % 2 == 0) ? 26 : 25;
      c  = (hh[li] + (longint'(1) << (w - 1))) >>> w;
      if (li == 9) hh[0] += 19 * c;
      else         hh[li + 1] += c;
      hh[li] -= c << w;
    end
    for (int i = 0; i < 10; i++) r[32*i +: 32] = hh[i][31:0];
    return r;
  endfunction

  function automatic logic [319:0] rand_fe();
    logic [319:0] r;
    int v;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) v = int'($urandom_range(0, (1 << 27) - 1)) - (1 << 26);
      else            v = int'($urandom_range(0, (1 << 26) - 1)) - (1 << 25);
      r[32*i +: 32] = v;
    end
    return r;
  endfunction

  // Issue one operation; valid stays high for 'hold' extra cycles with junk operands
  task automatic run_op(input string tag, input logic [319:0] a, input logic [319:0] b, input int hold);
    logic [319:0] exp;
    int n;
    exp   = fe_mul_ref(a, b);
    op_a  = a;
    op_b  = b;
    valid = 1'b1;
    @(posedge clk); #1;
    check_val({tag, "_done_clr"}, {319'd0, done}, 320'd0);
    n = 0;
    while (!done && n < 40) begin
      if (n < hold) begin
        valid = 1'b1;
        op_a  = rand_fe();
        op_b  = rand_fe();
      end else begin
        valid = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    valid = 1'b0;
    check_val({tag, "_latency"}, 320'(n), 320'd30);
    check_val({tag, "_res"}, res, exp);
  endtask

  logic [319:0] a5, b5, ta, tb, mx;
  bit seen;

  initial begin
    rst   = 1'b0;
    valid = 1'b0;
    op_a  = '0;
    op_b  = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    check_val("rst_res", res, 320'd0);
    check_val("rst_done", {319'd0, done}, 320'd0);
    repeat (6) @(posedge clk);
    #1;
    check_val("idle_done", {319'd0, done}, 320'd0);
    check_val("idle_res", res, 320'd0);

    run_op("unit", 320'h1, 320'h1, 0);
    check_val("unit_const", res, 320'h1);

    tb = '0;
    tb[32*9 +: 32] = 32'h0100_0000;
    run_op("fold", 320'h2, tb, 0);
    check_val("fold_const", res, 320'h13);

    ta = '0;
    ta[31:0] = 32'hFFFF_FFFF;
    run_op("neg", ta, 320'h5, 0);
    tb = '0;
    tb[31:0] = 32'hFFFF_FFFB;
    check_val("neg_const", res, tb);

    repeat (5) @(posedge clk);
    #1;
    check_val("hold_done", {319'd0, done}, 320'd1);
    check_val("hold_res", res, tb);

    a5 = 320'hfd83ef9a015fdac6fe99c76c00e7e9ab00d564f2ff4b49b3ff5d6d7f002ad3d10102ebd200f9adb1;
    b5 = 320'hffbcaf5f00f20b2efd5a3edaff514f9bfed39b5afee31a21fefb05d7fff31033019e1efbffc3571b;
    run_op("vec5", a5, b5, 0);

    // Limb-magnitude extremes, both signs
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 10; i++) begin
        if (i % 2 == 0) mx[32*i +: 32] = s[0] ? -(1 << 26) : (1 << 26) - 1;
        else            mx[32*i +: 32] = s[1] ? -(1 << 25) : (1 << 25) - 1;
      end
      run_op("extreme", mx, s[0] ? mx : rand_fe(), 0);
    end

    run_op("busy_valid", rand_fe(), rand_fe(), 10);

    // Abort mid-MUL: nothing may complete afterwards
    op_a  = rand_fe();
    op_b  = rand_fe();
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_val("abort_done", {319'd0, done}, 320'd0);
    check_val("abort_res", res, 320'd0);
    @(posedge clk); #1;
    rst  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check_val("abort_no_done", {319'd0, seen}, 320'd0);
    check_val("abort_res_hold", res, 320'd0);

    for (int i = 0; i < 1000; i++) run_op("rand", rand_fe(), rand_fe(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
